// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with post-reset clear sweep and pending-write scoreboard.
// Latency: reads are combinational (zero-latency); writes and scoreboard updates land at posedge.
// Backpressure: none; busy=1 during the clear sweep, when writes/sets are ignored and reads return 0.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   busy              1 while the clear sweep runs (file unusable)
//   rd_addr/rd_data   NRD read ports, port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   rd_pend           bit k = register addressed by read port k has a write in flight
//   we/wa/wd          writeback write port; writes to x0 are discarded and clear pend[wa]
//   sb_set/sb_addr    decode issue: mark sb_addr pending (wins over a same-cycle write clear)
//
// Optional feature: define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                busy,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]   rf_q [NREGS];
  logic [XLEN-1:0]   rf_d [NREGS];

  // Next-state for FSM, sweep pointer, register array and scoreboard.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rf_d    = rf_q;
    pend_d  = pend_q;
    case (state_q)
      CLEAR: begin
        rf_d[ptr_q] = '0;
        ptr_d       = ptr_q + AW'(1);
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (we && (wa != '0)) begin
          rf_d[wa]   = wd;
          pend_d[wa] = 1'b0;
        end
        // Applied after the write clear so a new producer issued in the
        // same cycle keeps the register pending.
        if (sb_set && (sb_addr != '0)) begin
          pend_d[sb_addr] = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    rf_d[0]   = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // Array contents are not reset; the sweep clears them once rst drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_q <= rf_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // Combinational read ports; everything reads as zero while the sweep runs.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      if (state_q == READY) begin
        if (rd_addr[k*AW +: AW] != '0) begin
          rd_data[k*XLEN +: XLEN] = rf_q[rd_addr[k*AW +: AW]];
          rd_pend[k]              = pend_q[rd_addr[k*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
          if (we && (wa != '0) && (rd_addr[k*AW +: AW] == wa)) begin
            rd_data[k*XLEN +: XLEN] = wd;
            rd_pend[k]              = sb_set && (sb_addr == wa);
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic                clk;
  logic                rst;
  logic                busy;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;

  int errors = 0;
  int checks = 0;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_pend (rd_pend),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .sb_set  (sb_set),
    .sb_addr (sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one posedge, then settle inputs 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0;
    rd_addr = {5'd6, 5'd5};

    // Reset state
    repeat (3) tick();
    #1;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rd_data0", rd_data[31:0], 32'd0);
    chk("reset_rd_data1", rd_data[63:32], 32'd0);
    chk("reset_rd_pend", 32'(rd_pend), 32'd0);

    // Sweep length: busy for 31 cycles after rst falls
    rst = 1'b0;
    repeat (30) tick();
    chk("sweep_busy_c30", 32'(busy), 32'd1);
    tick();
    chk("sweep_busy_c31", 32'(busy), 32'd0);
    for (int r = 0; r < NREGS; r++) begin
      set_rd(AW'(r), AW'(NREGS - 1 - r));
      chk("sweep_zero_p0", rd_data[31:0], 32'd0);
      chk("sweep_zero_p1", rd_data[63:32], 32'd0);
      chk("sweep_pend", 32'(rd_pend), 32'd0);
    end

    // Basic write/read
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    set_rd(5'd5, 5'd5);
    chk("rw_x5_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("rw_x5_p1", rd_data[63:32], 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    tick();
    we = 1'b0;
    set_rd(5'd0, 5'd0);
    chk("rw_x0_p0", rd_data[31:0], 32'd0);
    chk("rw_x0_p1", rd_data[63:32], 32'd0);

    // Scoreboard set, clear by write, set-wins on collision, x0 never pending
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    set_rd(5'd7, 5'd5);
    chk("sb_set_x7", 32'(rd_pend), 32'b01);
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    tick();
    we = 1'b0;
    set_rd(5'd7, 5'd5);
    chk("sb_clr_x7_pend", 32'(rd_pend), 32'b00);
    chk("sb_clr_x7_data", rd_data[31:0], 32'h77);
    we = 1'b1; wa = 5'd7; wd = 32'h88; sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    we = 1'b0; sb_set = 1'b0;
    set_rd(5'd7, 5'd7);
    chk("sb_collide_pend", 32'(rd_pend), 32'b11);
    chk("sb_collide_data", rd_data[63:32], 32'h88);
    sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    sb_set = 1'b0;
    set_rd(5'd0, 5'd7);
    chk("sb_x0_pend", 32'(rd_pend), 32'b10);

    // Same-cycle write/read of x3
    set_rd(5'd5, 5'd3);
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'd0;
`endif
    chk("bypass_x3_data", rd_data[63:32], exp_byp);
    chk("bypass_x3_pend", 32'(rd_pend), 32'b00);
    chk("bypass_p0_x5", rd_data[31:0], 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #1;
    chk("post_write_x3", rd_data[63:32], 32'hA5A5A5A5);

    // Preload x9 and make it pending
    we = 1'b1; wa = 5'd9; wd = 32'h55; sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    we = 1'b0; sb_set = 1'b0;
    set_rd(5'd9, 5'd7);
    chk("preload_x9_data", rd_data[31:0], 32'h55);
    chk("preload_pend", 32'(rd_pend), 32'b11);

    // Reset, then reset again mid-sweep while writes/sets are attempted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; wa = 5'd9; wd = 32'hFFFF; sb_set = 1'b1; sb_addr = 5'd9;
    repeat (10) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_rd_data", rd_data[31:0], 32'd0);
    chk("mid_rd_pend", 32'(rd_pend), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("restart_busy_c30", 32'(busy), 32'd1);
    tick();
    chk("restart_busy_c31", 32'(busy), 32'd0);
    we = 1'b0; sb_set = 1'b0;
    set_rd(5'd9, 5'd7);
    chk("after_rst_x9_data", rd_data[31:0], 32'd0);
    chk("after_rst_x7_data", rd_data[63:32], 32'd0);
    chk("after_rst_pend", 32'(rd_pend), 32'b00);
    set_rd(5'd5, 5'd3);
    chk("after_rst_x5", rd_data[31:0], 32'd0);
    chk("after_rst_x3", rd_data[63:32], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
